// File: rtl/mmio_bridge.sv
// mmio_bridge: data-side memory-map decoder for the single-cycle core.
// Routes loads/stores to data RAM or to the TX FIFO, status, timer and GPIO registers.
module mmio_bridge #(
   parameter int          FIFO_DEPTH = 8,
   parameter logic [31:0] IO_BASE    = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] mem_addr,
   input  logic        mem_we,
   input  logic [31:0] mem_wdata,
   output logic [31:0] mem_rdata,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   output logic [31:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  gpio_in
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(FIFO_DEPTH);

   localparam logic [1:0] OFF_TXDATA = 2'd0;
   localparam logic [1:0] OFF_STATUS = 2'd1;
   localparam logic [1:0] OFF_TIMER  = 2'd2;
   localparam logic [1:0] OFF_GPIO   = 2'd3;

   logic [PW-1:0] wptr_reg, wptr_next;
   logic [PW-1:0] rptr_reg, rptr_next;
   logic          overflow_reg, overflow_next;
   logic [31:0]   timer_reg, timer_next;
   logic [7:0]    sync1_reg, sync2_reg;
   logic [31:0]   fifo_mem [FIFO_DEPTH];

   logic          io_sel;
   logic [1:0]    offset;
   logic          io_we;
   logic          push_req, push, pop;
   logic          status_clr, timer_wr;
   logic [PW-1:0] count;
   logic [7:0]    count8;
   logic          empty, full;
   logic [31:0]   io_rdata;
   logic          unused_ok;

   // Byte-lane bits are not decoded: every register is word-wide.
   assign unused_ok = ^mem_addr[1:0];

   assign io_sel = (mem_addr[31:4] == IO_BASE[31:4]);
   assign offset = mem_addr[3:2];
   assign io_we  = mem_we & io_sel;

   assign ram_we    = mem_we & ~io_sel;
   assign ram_addr  = mem_addr;
   assign ram_wdata = mem_wdata;

   assign count  = wptr_reg - rptr_reg;
   assign count8 = 8'(count);
   assign empty  = (count == '0);
   assign full   = (count == DEPTH_P);

   assign push_req   = io_we & (offset == OFF_TXDATA);
   assign status_clr = io_we & (offset == OFF_STATUS) & mem_wdata[2];
   assign timer_wr   = io_we & (offset == OFF_TIMER);

   // Full is judged on pre-edge state, so a pop in the same cycle cannot rescue a push.
   assign push = push_req & ~full;
   assign pop  = ~empty & tx_ready;

   assign tx_valid = ~empty;
   assign tx_data  = empty ? 32'd0 : fifo_mem[rptr_reg[AW-1:0]];

   always_comb begin
      wptr_next     = push ? wptr_reg + 1'b1 : wptr_reg;
      rptr_next     = pop  ? rptr_reg + 1'b1 : rptr_reg;
      overflow_next = overflow_reg;
      if (push_req & full)
         overflow_next = 1'b1;
      else if (status_clr)
         overflow_next = 1'b0;
      timer_next = timer_wr ? mem_wdata : timer_reg + 32'd1;
   end

   always_comb begin
      io_rdata = 32'd0;
      case (offset)
         OFF_TXDATA: io_rdata = 32'd0;
         OFF_STATUS: io_rdata = {16'd0, count8, 5'd0, overflow_reg, full, empty};
         OFF_TIMER:  io_rdata = timer_reg;
         OFF_GPIO:   io_rdata = {24'd0, sync2_reg};
         default:    io_rdata = 32'd0;
      endcase
   end

   assign mem_rdata = io_sel ? io_rdata : ram_rdata;

   // Storage carries no reset; emptiness is defined purely by the pointers.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wptr_reg[AW-1:0]] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr_reg     <= '0;
         rptr_reg     <= '0;
         overflow_reg <= 1'b0;
         timer_reg    <= 32'd0;
         sync1_reg    <= 8'd0;
         sync2_reg    <= 8'd0;
      end else begin
         wptr_reg     <= wptr_next;
         rptr_reg     <= rptr_next;
         overflow_reg <= overflow_next;
         timer_reg    <= timer_next;
         sync1_reg    <= gpio_in;
         sync2_reg    <= sync1_reg;
      end
   end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed register accesses plus a
// scoreboard that checks every word handed to the TX peripheral.
module tb_mmio_bridge;

   localparam logic [31:0] IO_BASE = 32'hFFFF_0000;
   localparam logic [31:0] A_TX    = IO_BASE + 32'd0;
   localparam logic [31:0] A_ST    = IO_BASE + 32'd4;
   localparam logic [31:0] A_TM    = IO_BASE + 32'd8;
   localparam logic [31:0] A_GP    = IO_BASE + 32'd12;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we;
   logic        ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic [31:0] tx_data;
   logic        tx_valid, tx_ready;
   logic [7:0]  gpio_in;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q [$];

   mmio_bridge #(.FIFO_DEPTH(8), .IO_BASE(IO_BASE)) dut (
      .clk(clk), .reset(reset),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .gpio_in(gpio_in)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end else
         $display("ok   %s: %08h", name, act);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] data);
      mem_addr = addr;
      mem_we   = 1'b0;
      #1;
      data = mem_rdata;
   endtask

   task automatic io_write(input logic [31:0] addr, input logic [31:0] data);
      mem_addr  = addr;
      mem_wdata = data;
      mem_we    = 1'b1;
      tick();
      mem_we    = 1'b0;
   endtask

   // Monitor: every accepted handshake must match the oldest expected word.
   initial begin
      forever begin
         @(negedge clk);
         if (reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0)
               check("tx_unexpected_word", tx_data, 32'hDEAD_DEAD);
            else
               check("tx_word", tx_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [31:0] d;
      reset = 1'b0; mem_addr = 32'd0; mem_we = 1'b0; mem_wdata = 32'd0;
      ram_rdata = 32'd0; tx_ready = 1'b0; gpio_in = 8'hFF;

      // Reset state
      repeat (2) tick();
      check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("rst_tx_data", tx_data, 32'd0);
      rd(A_ST, d); check("rst_status", d, 32'h0000_0001);
      rd(A_TM, d); check("rst_timer", d, 32'd0);
      reset = 1'b1;
      rd(A_GP, d); check("gpio_c0", d, 32'd0);
      tick(); rd(A_GP, d); check("gpio_c1", d, 32'd0);
      tick(); rd(A_GP, d); check("gpio_c2", d, 32'h0000_00FF);

      // Three pushes then drain
      mem_addr = A_TX; mem_wdata = 32'h11; mem_we = 1'b1; #1;
      check("push_no_bypass", {31'd0, tx_valid}, 32'd0);
      tick(); mem_we = 1'b0; exp_q.push_back(32'h11);
      check("push_valid_next", {31'd0, tx_valid}, 32'd1);
      io_write(A_TX, 32'h22); exp_q.push_back(32'h22);
      io_write(A_TX, 32'h33); exp_q.push_back(32'h33);
      rd(A_ST, d); check("status_cnt3", d, 32'h0000_0300);
      rd(A_TX, d); check("txdata_read0", d, 32'd0);
      tx_ready = 1'b1;
      repeat (3) tick();
      tx_ready = 1'b0;
      check("drain_valid", {31'd0, tx_valid}, 32'd0);
      rd(A_ST, d); check("drain_status", d, 32'h0000_0001);

      // Overflow with nine pushes
      for (int i = 0; i < 9; i++) begin
         io_write(A_TX, 32'hA0 + 32'(i));
         if (i < 8) exp_q.push_back(32'hA0 + 32'(i));
      end
      rd(A_ST, d); check("status_ovf", d, 32'h0000_0806);
      io_write(A_ST, 32'd4);
      rd(A_ST, d); check("status_ovf_clr", d, 32'h0000_0802);
      tx_ready = 1'b1;
      repeat (8) tick();
      tx_ready = 1'b0;
      rd(A_ST, d); check("ovf_drain_status", d, 32'h0000_0001);
      check("ovf_queue_left", 32'(exp_q.size()), 32'd0);

      // Push while full with a simultaneous pop
      for (int i = 0; i < 8; i++) begin
         io_write(A_TX, 32'hB0 + 32'(i));
         exp_q.push_back(32'hB0 + 32'(i));
      end
      tx_ready = 1'b1;
      io_write(A_TX, 32'hB8);
      tx_ready = 1'b0;
      rd(A_ST, d); check("full_push_pop", d, 32'h0000_0704);
      io_write(A_ST, 32'd4);
      tx_ready = 1'b1;
      repeat (7) tick();
      tx_ready = 1'b0;
      rd(A_ST, d); check("full_drain_status", d, 32'h0000_0001);
      check("full_queue_left", 32'(exp_q.size()), 32'd0);

      // Timer load, wrap, and read-during-write
      io_write(A_TM, 32'hFFFF_FFFE);
      rd(A_TM, d); check("timer_fffe", d, 32'hFFFF_FFFE);
      tick(); rd(A_TM, d); check("timer_ffff", d, 32'hFFFF_FFFF);
      tick(); rd(A_TM, d); check("timer_wrap", d, 32'd0);
      io_write(A_TM, 32'd100);
      rd(A_TM, d); check("timer_load", d, 32'd100);
      mem_wdata = 32'd200; mem_we = 1'b1; #1;
      check("timer_rw_pre_edge", mem_rdata, 32'd100);
      tick(); mem_we = 1'b0;
      rd(A_TM, d); check("timer_load2", d, 32'd200);

      // RAM passthrough
      mem_addr = 32'h40; mem_wdata = 32'hABCD; mem_we = 1'b1; ram_rdata = 32'h5555_AAAA; #1;
      check("ram_we", {31'd0, ram_we}, 32'd1);
      check("ram_addr", ram_addr, 32'h40);
      check("ram_wdata", ram_wdata, 32'hABCD);
      check("ram_rdata", mem_rdata, 32'h5555_AAAA);
      tick(); mem_we = 1'b0;
      rd(A_ST, d); check("ram_no_fifo", d, 32'h0000_0001);
      mem_addr = A_ST; mem_wdata = 32'd0; mem_we = 1'b1; #1;
      check("io_ram_we", {31'd0, ram_we}, 32'd0);
      tick(); mem_we = 1'b0;
      rd(IO_BASE + 32'd7, d); check("ignore_lsbs", d, 32'h0000_0001);

      // GPIO change and mid-operation reset
      gpio_in = 8'h5A;
      tick(); tick();
      rd(A_GP, d); check("gpio_5a", d, 32'h0000_005A);
      io_write(A_TX, 32'hC0);
      io_write(A_TX, 32'hC1);
      reset = 1'b0; #1;
      exp_q.delete();
      check("midrst_valid", {31'd0, tx_valid}, 32'd0);
      check("midrst_data", tx_data, 32'd0);
      tick(); reset = 1'b1;
      rd(A_ST, d); check("midrst_status", d, 32'h0000_0001);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
